dmem_mmio_ctrl: RTL

DMEM_MMIO_CTRL -- requirements
Module: dmem_mmio_ctrl

---
 rtl/mem_pkg.sv | 68 ++++++
 rtl/sync_fifo.sv | 54 +++++
 rtl/dmem_mmio_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the data-memory / MMIO controller: funct3 size codes,
// MMIO register offsets, STATUS bit positions and byte-lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] OFF_TXDATA   = 32'h000;
  localparam logic [31:0] OFF_STATUS   = 32'h004;
  localparam logic [31:0] OFF_CYCLE_LO = 32'h008;
  localparam logic [31:0] OFF_CYCLE_HI = 32'h00C;
  localparam logic [31:0] OFF_HALT     = 32'h010;
  localparam logic [31:0] OFF_SCRATCH  = 32'h100;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;

  function automatic logic f3_legal(input logic [2:0] f3);
    return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  // sz is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  a);
    logic [31:0] sh;
    sh = word >> {a, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_BU:   return {24'h0, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_HU:   return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; accepts a push while full when
// a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             push_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] slot_mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && !do_push;
  assign head      = slot_mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slot_mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// Data-memory controller: byte-addressed RAM plus an MMIO window holding a
// console TX FIFO, a 64-bit cycle counter, a halt register and scratch RAM.
module dmem_mmio_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 262144,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned MMIO_BYTES = 1024,
  parameter int unsigned TXQ_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int MEM_AW    = $clog2(MEM_BYTES);
  localparam int MMIO_AW   = $clog2(MMIO_BYTES);
  localparam int RAM_WORDS = MEM_BYTES / 4;
  localparam int SCR_WORDS = (MMIO_BYTES - 256) / 4;
  localparam int SCR_IW    = MMIO_AW - 2;

  logic [31:0] ram_mem [RAM_WORDS];
  logic [31:0] scr_mem [SCR_WORDS];

  logic              req_ok, ram_hit, mmio_hit, scr_hit, reg_sel, fault;
  logic              ld_ok, st_ok, reg_wr, reg_rd, ovf_clr;
  logic [31:0]       off32, rd_word, wsh, status_word;
  logic [3:0]        be;
  logic [MEM_AW-3:0] ram_idx;
  logic [SCR_IW-1:0] scr_idx;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [7:0]  fifo_head;

  logic [63:0] cycle_q, cycle_d;
  logic [31:0] shadow_q, shadow_d;
  logic        ovf_q, ovf_d;
  logic        halt_q, halt_d;
  logic [31:0] halt_code_q, halt_code_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  // Address decode; the MMIO window is size-aligned so a tag compare suffices.
  assign req_ok   = req && !reset;
  assign ram_hit  = (addr[31:MEM_AW] == '0);
  assign mmio_hit = (addr[31:MMIO_AW] == MMIO_BASE[31:MMIO_AW]);
  assign off32    = 32'(addr[MMIO_AW-1:0]) & 32'hFFFF_FFFC;
  assign scr_hit  = mmio_hit && (off32 >= OFF_SCRATCH);
  assign reg_sel  = mmio_hit && !scr_hit;
  assign fault    = !f3_legal(funct3) || misaligned(funct3[1:0], addr[1:0]) ||
                    !(ram_hit || mmio_hit);

  assign ld_ok  = req_ok && !we && !fault;
  assign st_ok  = req_ok && we && !fault;
  assign reg_wr = st_ok && reg_sel;
  assign reg_rd = ld_ok && reg_sel;

  assign ram_idx = addr[MEM_AW-1:2];
  assign scr_idx = addr[MMIO_AW-1:2] - SCR_IW'(OFF_SCRATCH >> 2);
  assign be      = byte_en(funct3[1:0], addr[1:0]);
  assign wsh     = wdata << {addr[1:0], 3'b000};

  // STATUS bit2 lives in byte lane 0, so only stores touching that lane clear it.
  assign ovf_clr   = reg_wr && (off32 == OFF_STATUS) && be[0] && wsh[ST_OVF];
  assign fifo_push = reg_wr && (off32 == OFF_TXDATA);
  assign fifo_pop  = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (wdata[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_drop (fifo_drop)
  );

  always_comb begin
    status_word           = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_OVF]   = ovf_q;
  end

  always_comb begin
    rd_word = '0;
    if (ram_hit) begin
      rd_word = ram_mem[ram_idx];
    end else if (scr_hit) begin
      rd_word = scr_mem[scr_idx];
    end else if (reg_sel) begin
      case (off32)
        OFF_STATUS:   rd_word = status_word;
        OFF_CYCLE_LO: rd_word = cycle_q[31:0];
        OFF_CYCLE_HI: rd_word = shadow_q;
        OFF_HALT:     rd_word = halt_code_q;
        default:      rd_word = '0;
      endcase
    end
  end

  always_comb begin
    cycle_d     = cycle_q + 64'd1;
    shadow_d    = shadow_q;
    ovf_d       = ovf_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;

    // A counter write replaces the addressed half; the other half holds.
    if (reg_wr && off32 == OFF_CYCLE_LO)
      cycle_d = {cycle_q[63:32], merge_bytes(cycle_q[31:0], wsh, be)};
    if (reg_wr && off32 == OFF_CYCLE_HI)
      cycle_d = {merge_bytes(cycle_q[63:32], wsh, be), cycle_q[31:0]};

    if (reg_rd && off32 == OFF_CYCLE_LO) shadow_d = cycle_q[63:32];

    if (ovf_clr)   ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;

    if (reg_wr && off32 == OFF_HALT && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = wdata;
    end

    // Loads always respond; stores respond only when they fault.
    rvalid_d = req_ok && (!we || fault);
    err_d    = req_ok && fault;
    rdata_d  = ld_ok ? load_extract(rd_word, funct3, addr[1:0]) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q     <= '0;
      shadow_q    <= '0;
      ovf_q       <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cycle_q     <= cycle_d;
      shadow_q    <= shadow_d;
      ovf_q       <= ovf_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (st_ok && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram_mem[ram_idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (st_ok && scr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) scr_mem[scr_idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign tx_valid  = !fifo_empty;
  assign tx_data   = fifo_head;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

endmodule
